// File: rtl/demux_1to2_stream.sv
// ---------------------------------------------------------------------------
// demux_1to2_stream
//   Registered 1-to-2 stream demultiplexer. Each accepted input word is
//   steered to output port 0 or port 1 by select_i. Every output port has its
//   own one-entry register, so a stalled consumer blocks only the words that
//   are headed to its port.
//
//   Optional build macro: DEMUX_CNT_EN adds per-port drain counters
//   (cnt0_o, cnt1_o) and a synchronous clear input (cnt_clr_i).
//
// Parameters
//   size       data width of the input and of both output ports
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active low
//   data_i     input word
//   select_i   destination port: 0 or 1, meaningful only with valid_i
//   valid_i    producer offers data_i/select_i
//   ready_o    block takes the offered word this cycle (combinational)
//   data0_o    port 0 word         data1_o    port 1 word
//   valid0_o   port 0 holds a word valid1_o   port 1 holds a word
//   ready0_i   port 0 consumer takes the word
//   ready1_i   port 1 consumer takes the word
//   cnt0_o     (DEMUX_CNT_EN) port 0 drain count, wraps at 16 bits
//   cnt1_o     (DEMUX_CNT_EN) port 1 drain count, wraps at 16 bits
//   cnt_clr_i  (DEMUX_CNT_EN) zero both counters, wins over an increment
// ---------------------------------------------------------------------------

// One output port register: a single-entry skid-free stage.
module demux_port_reg #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic            drain,
  input  logic [size-1:0] din,
  output logic [size-1:0] dout,
  output logic            vld
);
  // load is only raised when the stage is empty or draining this cycle, so
  // a load always wins and keeps vld high across a drain+refill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (drain) begin
      vld  <= 1'b0;   // data is retained after a drain
    end
  end
endmodule

module demux_1to2_stream #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data1_o,
  output logic            valid1_o,
  input  logic            ready1_i
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]     cnt0_o,
  output logic [15:0]     cnt1_o,
  input  logic            cnt_clr_i
`endif
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]           port_rdy;   // consumer ready per port
  logic [NUM_PORTS-1:0]           port_vld;   // register occupied per port
  logic [NUM_PORTS-1:0]           port_free;  // can take a word this cycle
  logic [NUM_PORTS-1:0]           load;
  logic [NUM_PORTS-1:0]           drain;
  logic [NUM_PORTS-1:0][size-1:0] port_dat;
  logic                           accept;

  assign port_rdy = {ready1_i, ready0_i};

  // Gating with rst_i keeps ready_o low during reset.
  assign ready_o = rst_i & port_free[select_i];
  assign accept  = valid_i & ready_o;

  genvar n;
  generate
    for (n = 0; n < NUM_PORTS; n++) begin : g_port
      assign port_free[n] = ~port_vld[n] | port_rdy[n];
      assign drain[n]     = port_vld[n] & port_rdy[n];
      assign load[n]      = accept & (select_i == 1'(n));

      demux_port_reg #(.size(size)) u_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (load[n]),
        .drain (drain[n]),
        .din   (data_i),
        .dout  (port_dat[n]),
        .vld   (port_vld[n])
      );
    end
  endgenerate

  assign data0_o  = port_dat[0];
  assign data1_o  = port_dat[1];
  assign valid0_o = port_vld[0];
  assign valid1_o = port_vld[1];

`ifdef DEMUX_CNT_EN
  logic [NUM_PORTS-1:0][15:0] cnt_q;

  generate
    for (n = 0; n < NUM_PORTS; n++) begin : g_cnt
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)         cnt_q[n] <= '0;
        else if (cnt_clr_i) cnt_q[n] <= '0;
        else if (drain[n])  cnt_q[n] <= cnt_q[n] + 16'd1;  // natural wrap
      end
    end
  endgenerate

  assign cnt0_o = cnt_q[0];
  assign cnt1_o = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
module tb_demux_1to2_stream;
  localparam int size = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [size-1:0] data_i;
  logic            select_i;
  logic            valid_i;
  logic            ready_o;
  logic [size-1:0] data0_o;
  logic            valid0_o;
  logic            ready0_i;
  logic [size-1:0] data1_o;
  logic            valid1_o;
  logic            ready1_i;
`ifdef DEMUX_CNT_EN
  logic [15:0]     cnt0_o;
  logic [15:0]     cnt1_o;
  logic            cnt_clr_i;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  demux_1to2_stream #(.size(size)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0_o   (cnt0_o),
    .cnt1_o   (cnt1_o),
    .cnt_clr_i(cnt_clr_i)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic v, input logic s, input logic [31:0] d);
    valid_i  = v;
    select_i = s;
    data_i   = d;
    #1;
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b1; select_i = 1'b0; data_i = 32'h1234;
    ready0_i = 1'b1; ready1_i = 1'b1;
`ifdef DEMUX_CNT_EN
    cnt_clr_i = 1'b0;
`endif
    #12;
    // reset state
    chk("rst_v0", {31'd0, valid0_o}, 32'd0);
    chk("rst_v1", {31'd0, valid1_o}, 32'd0);
    chk("rst_d0", data0_o, 32'd0);
    chk("rst_d1", data1_o, 32'd0);
    chk("rst_rdy", {31'd0, ready_o}, 32'd0);
    tick();
    chk("rst_hold_v0", {31'd0, valid0_o}, 32'd0);
    offer(1'b0, 1'b0, 32'd0);
    rst_i = 1'b1;
    tick();

    // basic route to port 1
    offer(1'b1, 1'b1, 32'hDEADBEEF);
    chk("route_rdy", {31'd0, ready_o}, 32'd1);
    tick();
    chk("route_v1", {31'd0, valid1_o}, 32'd1);
    chk("route_d1", data1_o, 32'hDEADBEEF);
    chk("route_v0", {31'd0, valid0_o}, 32'd0);
    offer(1'b0, 1'b0, 32'h0);
    tick();
    chk("route_drain_v1", {31'd0, valid1_o}, 32'd0);
    chk("route_keep_d1", data1_o, 32'hDEADBEEF);

    // back-to-back stream to port 0
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 1'b0, 32'(i));
      chk($sformatf("b2b_rdy%0d", i), {31'd0, ready_o}, 32'd1);
      tick();
      chk($sformatf("b2b_v0_%0d", i), {31'd0, valid0_o}, 32'd1);
      chk($sformatf("b2b_d0_%0d", i), data0_o, 32'(i));
    end
    offer(1'b0, 1'b0, 32'h0);
    tick();
    chk("b2b_end_v0", {31'd0, valid0_o}, 32'd0);
    chk("b2b_end_d0", data0_o, 32'd7);

    // stall on port 0 while port 1 keeps flowing
    ready0_i = 1'b0;
    offer(1'b1, 1'b0, 32'h11);
    tick();
    chk("stall_load_d0", data0_o, 32'h11);
    offer(1'b1, 1'b0, 32'h22);
    chk("stall_rdy0", {31'd0, ready_o}, 32'd0);
    tick();
    chk("stall_hold_d0", data0_o, 32'h11);
    chk("stall_hold_v0", {31'd0, valid0_o}, 32'd1);
    offer(1'b1, 1'b1, 32'h33);
    chk("stall_rdy1", {31'd0, ready_o}, 32'd1);
    tick();
    chk("stall_d1", data1_o, 32'h33);
    chk("stall_v1", {31'd0, valid1_o}, 32'd1);
    chk("stall_d0_still", data0_o, 32'h11);

    // drain+refill on port 0
    ready0_i = 1'b1;
    offer(1'b1, 1'b0, 32'hA);
    chk("dr_rdy_a", {31'd0, ready_o}, 32'd1);
    tick();
    chk("dr_v0_a", {31'd0, valid0_o}, 32'd1);
    chk("dr_d0_a", data0_o, 32'hA);
    chk("dr_v1_drained", {31'd0, valid1_o}, 32'd0);
    offer(1'b1, 1'b0, 32'hB);
    chk("dr_rdy_b", {31'd0, ready_o}, 32'd1);
    tick();
    chk("dr_v0_b", {31'd0, valid0_o}, 32'd1);
    chk("dr_d0_b", data0_o, 32'hB);
    offer(1'b0, 1'b0, 32'h0);
    tick();
    chk("dr_end_v0", {31'd0, valid0_o}, 32'd0);

    // mid-cycle async reset with a word held
    ready0_i = 1'b0;
    offer(1'b1, 1'b0, 32'h55);
    tick();
    chk("mid_pre_v0", {31'd0, valid0_o}, 32'd1);
    offer(1'b1, 1'b1, 32'h66);
    #1 rst_i = 1'b0;
    #1;
    chk("mid_v0", {31'd0, valid0_o}, 32'd0);
    chk("mid_d0", data0_o, 32'd0);
    chk("mid_rdy", {31'd0, ready_o}, 32'd0);
    offer(1'b0, 1'b0, 32'h0);
    ready0_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

`ifdef DEMUX_CNT_EN
    chk("cnt_rst0", {16'd0, cnt0_o}, 32'd0);
    chk("cnt_rst1", {16'd0, cnt1_o}, 32'd0);
    offer(1'b1, 1'b1, 32'h77);
    for (int i = 0; i < 65537; i++) @(posedge clk_i);
    #1;
    offer(1'b0, 1'b0, 32'h0);
    tick();
    chk("cnt_wrap1", {16'd0, cnt1_o}, 32'd1);
    chk("cnt_wrap0", {16'd0, cnt0_o}, 32'd0);
    offer(1'b1, 1'b1, 32'h88);
    tick();
    offer(1'b0, 1'b0, 32'h0);
    cnt_clr_i = 1'b1;
    chk("cnt_pre_clr_v1", {31'd0, valid1_o}, 32'd1);
    tick();
    cnt_clr_i = 1'b0;
    chk("cnt_clr1", {16'd0, cnt1_o}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
